// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - operand forwarding, load-use interlock and perf counters over a STAGES-deep scoreboard
// Optional macro HAZARD_PERF_EN builds the cycle/stall/flush counters; otherwise they read as 0.
module hazard_fwd_unit #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int STAGES = 3,
  parameter int CNT_W  = 32
) (
  input  logic                     sysclk,
  input  logic                     cpu_resetn,
  input  logic                     issue_valid,
  input  logic [RA_W-1:0]          issue_wreg,
  input  logic [2:0]               issue_lat,
  input  logic [RA_W-1:0]          rs,
  input  logic [RA_W-1:0]          rt,
  input  logic                     rs_used,
  input  logic                     rt_used,
  input  logic [XLEN-1:0]          rf_rs,
  input  logic [XLEN-1:0]          rf_rt,
  input  logic [STAGES*XLEN-1:0]   stage_data,
  input  logic                     flush,
  input  logic                     halt,
  output logic [XLEN-1:0]          os_fwd,
  output logic [XLEN-1:0]          ot_fwd,
  output logic                     stall,
  output logic                     halted,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  logic [STAGES-1:0] vld_q, vld_d;
  logic [RA_W-1:0]   tag_q [STAGES];
  logic [RA_W-1:0]   tag_d [STAGES];
  logic [2:0]        lat_q [STAGES];
  logic [2:0]        lat_d [STAGES];
  logic              halted_q;
  logic              rs_haz, rt_haz;

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= '0;
        lat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      lat_q <= lat_d;
    end
  end

  // Unconditional shift; a stalled or flushed decode slot enters as a bubble.
  always_comb begin
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
      lat_d[i] = lat_q[i-1];
    end
    vld_d[0] = issue_valid && !stall && !flush && (issue_wreg != '0);
    tag_d[0] = issue_wreg;
    lat_d[0] = issue_lat;
  end

  // Scan oldest to youngest so the youngest matching entry has the final say.
  always_comb begin
    os_fwd = rf_rs;
    ot_fwd = rf_rt;
    rs_haz = 1'b0;
    rt_haz = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (vld_q[i] && (tag_q[i] == rs)) begin
        os_fwd = stage_data[i*XLEN +: XLEN];
        rs_haz = (3'(i) < lat_q[i]);
      end
      if (vld_q[i] && (tag_q[i] == rt)) begin
        ot_fwd = stage_data[i*XLEN +: XLEN];
        rt_haz = (3'(i) < lat_q[i]);
      end
    end
    if (rs == '0) begin
      os_fwd = '0;
      rs_haz = 1'b0;
    end
    if (rt == '0) begin
      ot_fwd = '0;
      rt_haz = 1'b0;
    end
  end

  assign stall = !flush && ((rs_used && rs_haz) || (rt_used && rt_haz));

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) halted_q <= 1'b0;
    else             halted_q <= halted_q | halt;
  end

  assign halted = halted_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] cycle_q, stall_q, flush_q;

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else if (!halted_q) begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (stall) stall_q <= stall_q + CNT_W'(1);
      if (flush) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
